freq_meter: RTL and testbench

FREQ_METER -- requirements
Module: freq_meter

---
 rtl/freq_meter.sv | 83 ++++++++
 tb/tb_freq_meter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_meter.sv
// rtl/freq_meter.sv - gated rising-edge counter for an asynchronous input
// Counts sig_in rising edges over GATE_CYCLES clk_in cycles and hands the result over a valid/ready pair.
module freq_meter #(
    parameter int unsigned CLK_HZ      = 50000000,
    parameter int unsigned GATE_CYCLES = CLK_HZ,
    parameter int unsigned CNT_W       = 27
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    input  logic             sig_in,
    output logic [CNT_W-1:0] freq_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             ovf,
    output logic             overrun
);
    localparam logic [31:0]      GATE_LAST = 32'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ECNT_MAX  = '1;

    logic             s1;
    logic             s2;
    logic             s3;
    logic             edge_det;
    logic [31:0]      gcnt;
    logic [CNT_W-1:0] ecnt;
    logic             sat;
    logic             win_end;
    logic             at_max;

    assign edge_det = s2 & ~s3;
    assign win_end  = en && (gcnt == GATE_LAST);
    assign at_max   = (ecnt == ECNT_MAX);

    always_ff @(posedge clk_in) begin
        if (rst) begin
            s1        <= 1'b0;
            s2        <= 1'b0;
            s3        <= 1'b0;
            gcnt      <= '0;
            ecnt      <= '0;
            sat       <= 1'b0;
            freq_out  <= '0;
            out_valid <= 1'b0;
            ovf       <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            s1      <= sig_in;
            s2      <= s1;
            s3      <= s2;
            overrun <= 1'b0;

            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            if (!en) begin
                gcnt <= '0;
                ecnt <= '0;
                sat  <= 1'b0;
            end else if (win_end) begin
                // The edge seen in the window-end cycle still belongs to the ending window.
                gcnt      <= '0;
                ecnt      <= '0;
                sat       <= 1'b0;
                freq_out  <= (edge_det && at_max) ? ECNT_MAX : ecnt + CNT_W'(edge_det);
                ovf       <= sat | (edge_det & at_max);
                out_valid <= 1'b1;
                overrun   <= out_valid & ~out_ready;
            end else begin
                gcnt <= gcnt + 32'd1;
                if (edge_det) begin
                    if (at_max) begin
                        sat <= 1'b1;
                    end else begin
                        ecnt <= ecnt + CNT_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_freq_meter.sv
// tb/tb_freq_meter.sv - randomized self-checking bench for freq_meter
module tb_freq_meter;
    localparam int GATE = 100;

    logic        clk_in    = 1'b0;
    logic        rst       = 1'b1;
    logic        en        = 1'b0;
    logic        sig_in    = 1'b0;
    logic        out_ready = 1'b1;
    logic [26:0] freq_a;
    logic [2:0]  freq_b;
    logic        valid_a, valid_b, ovf_a, ovf_b, overrun_a, overrun_b;

    int cyc   = 0;
    int tests = 0;
    int fails = 0;
    bit hist [0:16383];

    freq_meter #(.CLK_HZ(50000000), .GATE_CYCLES(GATE), .CNT_W(27)) dut_a (
        .clk_in(clk_in), .rst(rst), .en(en), .sig_in(sig_in),
        .freq_out(freq_a), .out_valid(valid_a), .out_ready(out_ready),
        .ovf(ovf_a), .overrun(overrun_a)
    );

    freq_meter #(.CLK_HZ(50000000), .GATE_CYCLES(GATE), .CNT_W(3)) dut_b (
        .clk_in(clk_in), .rst(rst), .en(en), .sig_in(sig_in),
        .freq_out(freq_b), .out_valid(valid_b), .out_ready(out_ready),
        .ovf(ovf_b), .overrun(overrun_b)
    );

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    // Reference: a rise driven in cycle r is detected in cycle r+2; count detections in [lo, hi].
    function automatic int count_det(input int lo, input int hi);
        int n = 0;
        for (int c = lo; c <= hi; c++) begin
            if (hist[c-2] && !hist[c-3]) n++;
        end
        return n;
    endfunction

    task automatic step_bit(input bit s);
        @(posedge clk_in);
        #1;
        sig_in    = s;
        hist[cyc] = s;
    endtask

    // per > 0: square wave of that period anchored at base; 0: low; < 0: random.
    task automatic step(input int per, input int base);
        bit s;
        if (per < 0)       s = 1'($urandom_range(0, 1));
        else if (per == 0) s = 1'b0;
        else               s = (((cyc + 1 - base) % per) < (per / 2));
        step_bit(s);
    endtask

    task automatic run_to(input int target, input int per, input int base);
        while (cyc < target) step(per, base);
    endtask

    // Reset clears the synchronizer, so the two samples still in flight are lost.
    task automatic do_reset();
        rst = 1'b1;
        en  = 1'b0;
        step_bit(1'b0);
        step_bit(1'b0);
        hist[cyc-1] = 1'b0;
        hist[cyc-2] = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step_bit(1'b0);
        step_bit(1'b0);
        step_bit(1'b0);
        tests++; if (freq_a !== 27'd0) begin fails++; $display("FAIL reset freq_a: got %0d want 0", freq_a); end
        tests++; if (valid_a !== 1'b0) begin fails++; $display("FAIL reset valid_a: got %0b want 0", valid_a); end
        tests++; if (ovf_a !== 1'b0) begin fails++; $display("FAIL reset ovf_a: got %0b want 0", ovf_a); end
        tests++; if (overrun_a !== 1'b0) begin fails++; $display("FAIL reset overrun_a: got %0b want 0", overrun_a); end
        tests++; if (freq_b !== 3'd0) begin fails++; $display("FAIL reset freq_b: got %0d want 0", freq_b); end
        tests++; if (valid_b !== 1'b0) begin fails++; $display("FAIL reset valid_b: got %0b want 0", valid_b); end
        rst = 1'b0;
    endtask

    task automatic test_windows();
        int e, exp;
        out_ready = 1'b1;
        do_reset();
        en = 1'b1;
        e  = cyc;
        for (int w = 1; w <= 5; w++) begin
            run_to(e + GATE * w, (w <= 3) ? 10 : -1, e);
            exp = (w <= 3) ? 10 : count_det(e + GATE * (w - 1), e + GATE * w - 1);
            tests++; if (valid_a !== 1'b1) begin fails++; $display("FAIL win%0d valid: got %0b want 1", w, valid_a); end
            tests++; if (freq_a !== 27'(exp)) begin fails++; $display("FAIL win%0d freq: got %0d want %0d", w, freq_a, exp); end
            tests++; if (ovf_a !== 1'b0) begin fails++; $display("FAIL win%0d ovf: got %0b want 0", w, ovf_a); end
            tests++; if (overrun_a !== 1'b0) begin fails++; $display("FAIL win%0d overrun: got %0b want 0", w, overrun_a); end
            step((w <= 3) ? 10 : -1, e);
            tests++; if (valid_a !== 1'b0) begin fails++; $display("FAIL win%0d valid pulse: got %0b want 0", w, valid_a); end
        end
    endtask

    task automatic test_saturate();
        int e, exp;
        out_ready = 1'b1;
        do_reset();
        en = 1'b1;
        e  = cyc;
        for (int w = 1; w <= 3; w++) begin
            run_to(e + GATE * w, (w <= 2) ? 4 : 50, e);
            exp = count_det(e + GATE * (w - 1), e + GATE * w - 1);
            tests++; if (freq_a !== 27'(exp)) begin fails++; $display("FAIL sat%0d freq_a: got %0d want %0d", w, freq_a, exp); end
            tests++; if (freq_b !== 3'((exp > 7) ? 7 : exp)) begin fails++; $display("FAIL sat%0d freq_b: got %0d want %0d", w, freq_b, (exp > 7) ? 7 : exp); end
            tests++; if (ovf_b !== 1'(exp > 7)) begin fails++; $display("FAIL sat%0d ovf_b: got %0b want %0b", w, ovf_b, exp > 7); end
        end
    endtask

    task automatic test_overrun();
        int e, exp1, exp2;
        out_ready = 1'b0;
        do_reset();
        en = 1'b1;
        e  = cyc;
        run_to(e + GATE, 10, e);
        exp1 = count_det(e, e + GATE - 1);
        tests++; if (freq_a !== 27'(exp1)) begin fails++; $display("FAIL ovr w1 freq: got %0d want %0d", freq_a, exp1); end
        tests++; if (overrun_a !== 1'b0) begin fails++; $display("FAIL ovr w1 overrun: got %0b want 0", overrun_a); end
        run_to(e + 2 * GATE, 5, e);
        exp2 = count_det(e + GATE, e + 2 * GATE - 1);
        en = 1'b0;
        tests++; if (overrun_a !== 1'b1) begin fails++; $display("FAIL ovr w2 overrun: got %0b want 1", overrun_a); end
        tests++; if (freq_a !== 27'(exp2)) begin fails++; $display("FAIL ovr w2 freq: got %0d want %0d", freq_a, exp2); end
        tests++; if (valid_a !== 1'b1) begin fails++; $display("FAIL ovr w2 valid: got %0b want 1", valid_a); end
        step_bit(1'b0);
        tests++; if (overrun_a !== 1'b0) begin fails++; $display("FAIL ovr pulse: got %0b want 0", overrun_a); end
        tests++; if (freq_a !== 27'(exp2)) begin fails++; $display("FAIL ovr hold freq: got %0d want %0d", freq_a, exp2); end
        out_ready = 1'b1;
        step_bit(1'b0);
        tests++; if (valid_a !== 1'b0) begin fails++; $display("FAIL ovr consume valid: got %0b want 0", valid_a); end
    endtask

    task automatic test_back_to_back();
        int e, exp;
        out_ready = 1'b0;
        do_reset();
        en = 1'b1;
        e  = cyc;
        run_to(e + 2 * GATE - 1, -1, e);
        out_ready = 1'b1;
        run_to(e + 2 * GATE, -1, e);
        exp = count_det(e + GATE, e + 2 * GATE - 1);
        tests++; if (valid_a !== 1'b1) begin fails++; $display("FAIL b2b valid: got %0b want 1", valid_a); end
        tests++; if (overrun_a !== 1'b0) begin fails++; $display("FAIL b2b overrun: got %0b want 0", overrun_a); end
        tests++; if (freq_a !== 27'(exp)) begin fails++; $display("FAIL b2b freq: got %0d want %0d", freq_a, exp); end
        step(-1, e);
        tests++; if (valid_a !== 1'b0) begin fails++; $display("FAIL b2b clear: got %0b want 0", valid_a); end
    endtask

    task automatic test_boundary();
        int e, off;
        int want [3] = '{1, 0, 1};
        out_ready = 1'b1;
        do_reset();
        en = 1'b1;
        e  = cyc;
        for (int w = 0; w < 3; w++) begin
            while (cyc < e + GATE * (w + 1)) begin
                off = cyc + 1 - e;
                step_bit(off == 97 || off == 98 || off == 198 || off == 199);
            end
            tests++; if (freq_a !== 27'(want[w])) begin fails++; $display("FAIL boundary w%0d freq: got %0d want %0d", w + 1, freq_a, want[w]); end
            tests++; if (freq_a !== 27'(count_det(e + GATE * w, e + GATE * w + GATE - 1))) begin fails++; $display("FAIL boundary w%0d model: got %0d", w + 1, freq_a); end
        end
    endtask

    task automatic test_reset_mid();
        int e, e2, exp;
        out_ready = 1'b0;
        do_reset();
        en = 1'b1;
        e  = cyc;
        run_to(e + GATE, 10, e);
        tests++; if (valid_a !== 1'b1) begin fails++; $display("FAIL rstmid pending valid: got %0b want 1", valid_a); end
        run_to(e + GATE + 50, 10, e);
        rst = 1'b1;
        step_bit(1'b0);
        hist[cyc-1] = 1'b0;
        hist[cyc-2] = 1'b0;
        tests++; if (freq_a !== 27'd0 || valid_a !== 1'b0 || ovf_a !== 1'b0 || overrun_a !== 1'b0) begin fails++; $display("FAIL rstmid outputs: got freq %0d valid %0b ovf %0b overrun %0b want all 0", freq_a, valid_a, ovf_a, overrun_a); end
        rst = 1'b0;
        out_ready = 1'b1;
        e2 = cyc;
        run_to(e2 + GATE - 1, 10, e);
        tests++; if (valid_a !== 1'b0) begin fails++; $display("FAIL rstmid early valid: got %0b want 0", valid_a); end
        run_to(e2 + GATE, 10, e);
        exp = count_det(e2, e2 + GATE - 1);
        tests++; if (valid_a !== 1'b1) begin fails++; $display("FAIL rstmid result valid: got %0b want 1", valid_a); end
        tests++; if (freq_a !== 27'(exp)) begin fails++; $display("FAIL rstmid freq: got %0d want %0d", freq_a, exp); end
    endtask

    task automatic test_en_gap();
        int e, e2, exp;
        bit seen = 1'b0;
        out_ready = 1'b1;
        do_reset();
        en = 1'b1;
        e  = cyc;
        run_to(e + 60, 10, e);
        en = 1'b0;
        while (cyc < e + 90) begin
            step(10, e);
            if (valid_a) seen = 1'b1;
        end
        en = 1'b1;
        e2 = cyc;
        while (cyc < e2 + GATE - 1) begin
            step(-1, e);
            if (valid_a) seen = 1'b1;
        end
        tests++; if (seen !== 1'b0) begin fails++; $display("FAIL engap early result: got %0b want 0", seen); end
        run_to(e2 + GATE, -1, e);
        exp = count_det(e2, e2 + GATE - 1);
        tests++; if (valid_a !== 1'b1) begin fails++; $display("FAIL engap valid: got %0b want 1", valid_a); end
        tests++; if (freq_a !== 27'(exp)) begin fails++; $display("FAIL engap freq: got %0d want %0d", freq_a, exp); end
    endtask

    initial begin
        test_reset();
        test_windows();
        test_saturate();
        test_overrun();
        test_back_to_back();
        test_boundary();
        test_reset_mid();
        test_en_gap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
